// File: rtl/ofdm_symbol_framer.sv
// OFDM symbol framer: on a timing trigger, skips an offset, then cuts the
// sample stream into num_frames frames of frame_len samples (tlast on each
// frame end), discarding gap_len cyclic-prefix samples between frames.
// Datapath is pure gating; control state is registered.
module ofdm_symbol_framer #(
   parameter int SR_BASE            = 16,
   parameter int DEFAULT_FRAME_LEN  = 64,
   parameter int DEFAULT_GAP_LEN    = 16,
   parameter int DEFAULT_OFFSET     = 0,
   parameter int DEFAULT_NUM_FRAMES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   input  logic        i_trigger,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [15:0] o_frame_idx,
   output logic        busy
);

   localparam logic [7:0] ADDR_FLEN = 8'(SR_BASE);
   localparam logic [7:0] ADDR_GAP  = 8'(SR_BASE + 1);
   localparam logic [7:0] ADDR_OFF  = 8'(SR_BASE + 2);
   localparam logic [7:0] ADDR_NUM  = 8'(SR_BASE + 3);

   typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_FRAME, S_GAP} state_t;

   state_t      state_q;
   logic [15:0] cfg_flen_q, cfg_gap_q, cfg_off_q, cfg_num_q;
   logic [15:0] sh_flen_q, sh_gap_q, sh_off_q, sh_num_q;
   logic [15:0] cnt_q, fidx_q;
   logic [15:0] cnt_d, fidx_d;
   logic [15:0] cfg_flen_eff;
   logic        trig_hit, direct, pass, beat;
   logic        frame_end, last_frame;
   logic        unused_bits;

   // Input tlast and the upper settings half carry no meaning here.
   assign unused_bits = ^{i_tlast, set_data[31:16]};

   // A zero frame length behaves as a single-sample frame.
   assign cfg_flen_eff = (cfg_flen_q == 16'd0) ? 16'd1 : cfg_flen_q;

   // With zero offset the trigger beat itself is frame sample 0, so it is
   // routed through the pass-through path while still in IDLE.
   assign trig_hit = (state_q == S_IDLE) && i_tvalid && i_trigger && (cfg_num_q != 16'd0);
   assign direct   = trig_hit && (cfg_off_q == 16'd0);
   assign pass     = (state_q == S_FRAME) || direct;

   assign o_tdata     = i_tdata;
   assign o_tvalid    = pass && i_tvalid;
   assign i_tready    = pass ? o_tready : 1'b1;
   assign beat        = i_tvalid && i_tready;
   assign o_frame_idx = fidx_q;
   assign busy        = (state_q != S_IDLE);

   assign frame_end  = (cnt_q == sh_flen_q - 16'd1);
   assign last_frame = (fidx_q == sh_num_q - 16'd1);
   assign o_tlast    = ((state_q == S_FRAME) && frame_end) ||
                       (direct && (cfg_flen_eff == 16'd1));

   assign cnt_d  = cnt_q + 16'd1;
   assign fidx_d = fidx_q + 16'd1;

   // Settings registers, written from the settings bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_flen_q <= 16'(DEFAULT_FRAME_LEN);
         cfg_gap_q  <= 16'(DEFAULT_GAP_LEN);
         cfg_off_q  <= 16'(DEFAULT_OFFSET);
         cfg_num_q  <= 16'(DEFAULT_NUM_FRAMES);
      end else if (set_stb) begin
         if (set_addr == ADDR_FLEN) cfg_flen_q <= set_data[15:0];
         if (set_addr == ADDR_GAP)  cfg_gap_q  <= set_data[15:0];
         if (set_addr == ADDR_OFF)  cfg_off_q  <= set_data[15:0];
         if (set_addr == ADDR_NUM)  cfg_num_q  <= set_data[15:0];
      end
   end

   // Framing FSM: shadows latched on trigger, counters advance on accepted beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         fidx_q    <= 16'd0;
         sh_flen_q <= 16'(DEFAULT_FRAME_LEN);
         sh_gap_q  <= 16'(DEFAULT_GAP_LEN);
         sh_off_q  <= 16'(DEFAULT_OFFSET);
         sh_num_q  <= 16'(DEFAULT_NUM_FRAMES);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (beat && i_trigger && (cfg_num_q != 16'd0)) begin
                  sh_flen_q <= cfg_flen_eff;
                  sh_gap_q  <= cfg_gap_q;
                  sh_off_q  <= cfg_off_q;
                  sh_num_q  <= cfg_num_q;
                  fidx_q    <= 16'd0;
                  cnt_q     <= 16'd0;
                  if (cfg_off_q == 16'd0) begin
                     if (cfg_flen_eff != 16'd1) begin
                        state_q <= S_FRAME;
                        cnt_q   <= 16'd1;
                     end else if (cfg_num_q == 16'd1) begin
                        state_q <= S_IDLE;
                     end else if (cfg_gap_q == 16'd0) begin
                        state_q <= S_FRAME;
                        fidx_q  <= 16'd1;
                     end else begin
                        state_q <= S_GAP;
                     end
                  end else if (cfg_off_q == 16'd1) begin
                     state_q <= S_FRAME;
                  end else begin
                     state_q <= S_OFFSET;
                     cnt_q   <= 16'd1;
                  end
               end
            end
            S_OFFSET: begin
               if (beat) begin
                  if (cnt_q == sh_off_q - 16'd1) begin
                     state_q <= S_FRAME;
                     cnt_q   <= 16'd0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            S_FRAME: begin
               if (beat) begin
                  if (frame_end) begin
                     cnt_q <= 16'd0;
                     if (last_frame) begin
                        state_q <= S_IDLE;
                        fidx_q  <= 16'd0;
                     end else if (sh_gap_q == 16'd0) begin
                        fidx_q <= fidx_d;
                     end else begin
                        state_q <= S_GAP;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            default: begin
               if (beat) begin
                  if (cnt_q == sh_gap_q - 16'd1) begin
                     state_q <= S_FRAME;
                     cnt_q   <= 16'd0;
                     fidx_q  <= fidx_d;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench for ofdm_symbol_framer: ramp input, hand-derived frame layout.
module tb_ofdm_symbol_framer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic [31:0] i_tdata = 32'd0;
   logic        i_tlast = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        i_tready;
   logic        i_trigger = 1'b0;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready = 1'b1;
   logic [15:0] o_frame_idx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_data[$];
   logic        q_last[$];
   logic [15:0] q_idx[$];
   bit          busy_log[0:4095];
   bit          busy_any;

   ofdm_symbol_framer dut (
      .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .i_trigger(i_trigger), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
      .o_tready(o_tready), .o_frame_idx(o_frame_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic write_reg(input logic [7:0] addr, input logic [15:0] data);
      set_stb  = 1'b1;
      set_addr = addr;
      set_data = {16'd0, data};
      @(posedge clk); #1;
      set_stb  = 1'b0;
   endtask

   task automatic cfg(input int flen, input int gap, input int off, input int num);
      write_reg(8'd16, 16'(flen));
      write_reg(8'd17, 16'(gap));
      write_reg(8'd18, 16'(off));
      write_reg(8'd19, 16'(num));
   endtask

   // Drives a ramp 0..stop (value = index), captures output beats and busy.
   // Returns early (at the negedge, beat not accepted) when value rst_at is presented.
   task automatic drive_ramp(input int stop, input int ta, input int tb2, input int tc,
                             input bit rnd, input int wr_at, input logic [7:0] wr_addr,
                             input logic [15:0] wr_data, input int rst_at);
      int v = 0;
      int cyc = 0;
      bit acc;
      bit wr_done = 1'b0;
      q_data.delete(); q_last.delete(); q_idx.delete();
      busy_any = 1'b0;
      for (int i = 0; i < 4096; i++) busy_log[i] = 1'b0;
      while (v <= stop) begin
         i_tvalid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         o_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         i_tdata   = 32'(v);
         i_trigger = (v == ta) || (v == tb2) || (v == tc);
         set_stb   = (v == wr_at) && !wr_done;
         set_addr  = wr_addr;
         set_data  = {16'd0, wr_data};
         @(negedge clk);
         if (v == rst_at && i_tvalid) return;
         acc = i_tvalid && i_tready;
         if (i_tvalid) busy_log[v] = busy;
         busy_any = busy_any | busy;
         if (o_tvalid && o_tready) begin
            q_data.push_back(o_tdata);
            q_last.push_back(o_tlast);
            q_idx.push_back(o_frame_idx);
         end
         if (set_stb) wr_done = 1'b1;
         @(posedge clk); #1;
         set_stb = 1'b0;
         if (acc) v++;
         cyc++;
         if (cyc > 20000) begin
            n_checks++; n_fail++;
            $display("FAIL ramp_timeout reached value %0d, required %0d", v, stop);
            break;
         end
      end
      i_tvalid = 1'b0; i_trigger = 1'b0; o_tready = 1'b1; set_stb = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", o_tvalid); end
      n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", o_tlast); end
      n_checks++; if (o_frame_idx !== 16'd0) begin n_fail++; $display("FAIL rst_idx got %0d want 0", o_frame_idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready got %b want 1", i_tready); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || i_tready !== 1'b1) begin n_fail++; $display("FAIL post_rst busy=%b tready=%b want 0/1", busy, i_tready); end
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_main_burst;
      cfg(64, 16, 29, 12);
      drive_ramp(1200, 100, -1, -1, 1'b0, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 768) begin n_fail++; $display("FAIL main_count got %0d want 768", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 768; i++) begin
         int k = i / 64; int j = i % 64;
         n_checks++;
         if (q_data[i] !== 32'(129 + 80 * k + j) || q_last[i] !== (j == 63) || q_idx[i] !== 16'(k)) begin
            n_fail++;
            $display("FAIL main_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=%0d",
                     i, q_data[i], q_last[i], q_idx[i], 129 + 80 * k + j, (j == 63), k);
         end
      end
      n_checks++; if (busy_log[99] !== 1'b0) begin n_fail++; $display("FAIL main_busy_pre got %b want 0", busy_log[99]); end
      n_checks++; if (busy_log[128] !== 1'b1) begin n_fail++; $display("FAIL main_busy_offset got %b want 1", busy_log[128]); end
      n_checks++; if (busy_log[1072] !== 1'b1) begin n_fail++; $display("FAIL main_busy_last got %b want 1", busy_log[1072]); end
      n_checks++; if (busy_log[1073] !== 1'b0) begin n_fail++; $display("FAIL main_busy_after got %b want 0", busy_log[1073]); end
      $display("test_main_burst done: %0d beats", q_data.size());
   endtask

   task automatic test_contig;
      cfg(4, 0, 0, 3);
      drive_ramp(30, 10, -1, -1, 1'b0, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL contig_count got %0d want 12", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 12; i++) begin
         n_checks++;
         if (q_data[i] !== 32'(10 + i) || q_last[i] !== (i % 4 == 3) || q_idx[i] !== 16'(i / 4)) begin
            n_fail++;
            $display("FAIL contig_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=%0d",
                     i, q_data[i], q_last[i], q_idx[i], 10 + i, (i % 4 == 3), i / 4);
         end
      end
      n_checks++; if (busy_log[10] !== 1'b0) begin n_fail++; $display("FAIL contig_busy_trig got %b want 0", busy_log[10]); end
      n_checks++; if (busy_log[21] !== 1'b1) begin n_fail++; $display("FAIL contig_busy_last got %b want 1", busy_log[21]); end
      n_checks++; if (busy_log[22] !== 1'b0) begin n_fail++; $display("FAIL contig_busy_after got %b want 0", busy_log[22]); end
      $display("test_contig done: %0d beats", q_data.size());
   endtask

   task automatic test_backpressure;
      cfg(64, 16, 29, 12);
      drive_ramp(1200, 100, -1, -1, 1'b1, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 768) begin n_fail++; $display("FAIL bp_count got %0d want 768", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 768; i++) begin
         int k = i / 64; int j = i % 64;
         n_checks++;
         if (q_data[i] !== 32'(129 + 80 * k + j) || q_last[i] !== (j == 63) || q_idx[i] !== 16'(k)) begin
            n_fail++;
            $display("FAIL bp_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=%0d",
                     i, q_data[i], q_last[i], q_idx[i], 129 + 80 * k + j, (j == 63), k);
         end
      end
      $display("test_backpressure done: %0d beats", q_data.size());
   endtask

   task automatic test_retrigger;
      drive_ramp(2100, 100, 300, 1100, 1'b0, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 1536) begin n_fail++; $display("FAIL retrig_count got %0d want 1536", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 1536; i++) begin
         int b = i / 768; int k = (i % 768) / 64; int j = i % 64;
         n_checks++;
         if (q_data[i] !== 32'(129 + 1000 * b + 80 * k + j) || q_last[i] !== (j == 63) || q_idx[i] !== 16'(k)) begin
            n_fail++;
            $display("FAIL retrig_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=%0d",
                     i, q_data[i], q_last[i], q_idx[i], 129 + 1000 * b + 80 * k + j, (j == 63), k);
         end
      end
      $display("test_retrigger done: %0d beats", q_data.size());
   endtask

   task automatic test_shadow;
      cfg(64, 4, 2, 2);
      drive_ramp(300, 10, 200, -1, 1'b0, 50, 8'd16, 16'd32, -1);
      n_checks++; if (q_data.size() !== 192) begin n_fail++; $display("FAIL shadow_count got %0d want 192", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 192; i++) begin
         int k; int j; int ed;
         bit el;
         if (i < 128) begin k = i / 64; j = i % 64; ed = 12 + 68 * k + j; el = (j == 63); end
         else begin k = (i - 128) / 32; j = (i - 128) % 32; ed = 202 + 36 * k + j; el = (j == 31); end
         n_checks++;
         if (q_data[i] !== 32'(ed) || q_last[i] !== el || q_idx[i] !== 16'(k)) begin
            n_fail++;
            $display("FAIL shadow_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=%0d",
                     i, q_data[i], q_last[i], q_idx[i], ed, el, k);
         end
      end
      $display("test_shadow done: %0d beats", q_data.size());
   endtask

   task automatic test_num_zero;
      write_reg(8'd19, 16'd0);
      drive_ramp(50, 5, -1, -1, 1'b0, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL numzero_count got %0d want 0", q_data.size()); end
      n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL numzero_busy got %b want 0", busy_any); end
      $display("test_num_zero done: %0d beats", q_data.size());
   endtask

   task automatic test_reset_mid;
      cfg(64, 16, 29, 12);
      drive_ramp(1200, 100, -1, -1, 1'b0, -1, 8'd0, 16'd0, 380);
      n_checks++; if (o_tvalid !== 1'b1 || o_frame_idx !== 16'd3) begin n_fail++; $display("FAIL rstmid_pre got tvalid=%b idx=%0d want 1/3", o_tvalid, o_frame_idx); end
      n_checks++; if (q_data.size() !== 203) begin n_fail++; $display("FAIL rstmid_count got %0d want 203", q_data.size()); end
      reset = 1'b1;
      #1;
      n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b want 0", o_tvalid); end
      n_checks++; if (o_tlast !== 1'b0 || o_frame_idx !== 16'd0) begin n_fail++; $display("FAIL rstmid_tlast_idx got %b/%0d want 0/0", o_tlast, o_frame_idx); end
      n_checks++; if (busy !== 1'b0 || i_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_tready got %b/%b want 0/1", busy, i_tready); end
      i_tvalid = 1'b0; i_trigger = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      drive_ramp(100, 7, -1, -1, 1'b0, -1, 8'd0, 16'd0, -1);
      n_checks++; if (q_data.size() !== 64) begin n_fail++; $display("FAIL rstdef_count got %0d want 64", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 64; i++) begin
         n_checks++;
         if (q_data[i] !== 32'(7 + i) || q_last[i] !== (i == 63) || q_idx[i] !== 16'd0) begin
            n_fail++;
            $display("FAIL rstdef_beat[%0d] got data=%0d last=%b idx=%0d want data=%0d last=%b idx=0",
                     i, q_data[i], q_last[i], q_idx[i], 7 + i, (i == 63));
         end
      end
      n_checks++; if (busy_log[71] !== 1'b0) begin n_fail++; $display("FAIL rstdef_busy_after got %b want 0", busy_log[71]); end
      $display("test_reset_mid done: %0d beats", q_data.size());
   endtask

   initial begin
      test_reset();
      test_main_burst();
      test_contig();
      test_backpressure();
      test_retrigger();
      test_shadow();
      test_num_zero();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ofdm_symbol_framer.md
# ofdm_symbol_framer

Trigger-driven OFDM symbol framer sitting directly downstream of the Schmidl-Cox timing detector inside `noc_block_schmidl_cox`, and upstream of the FFT. On a timing trigger it skips a programmable offset. It then emits a programmable number of fixed-length frames (FFT size) as AXI-stream packets, each terminated with tlast, and discards a programmable gap (cyclic prefix) between frames. Every sample outside a frame is consumed and dropped.

## Interface
Parameters:
- `SR_BASE`, 16: settings-bus base address; registers at `SR_BASE+0..4`.
- `DEFAULT_FRAME_LEN`, 64: reset value of frame length.
- `DEFAULT_GAP_LEN`, 16: reset value of gap length.
- `DEFAULT_OFFSET`, 0: reset value of trigger-to-first-frame offset.
- `DEFAULT_NUM_FRAMES`, 1: reset value of frames per trigger.

Ports:
- `clk` in 1: single clock for everything.
- `reset` in 1: asynchronous, active-high.
- `set_stb` in 1: settings write strobe.
- `set_addr` in 8: settings address.
- `set_data` in 32: settings data; low 16 bits used.
- `i_tdata` in 32: sc16 sample (I[31:16], Q[15:0]).
- `i_tlast` in 1: ignored.
- `i_tvalid` in 1: input valid.
- `i_tready` out 1: input ready.
- `i_trigger` in 1: sideband qualified by the input handshake; marks the beat that is sample 0 of a burst.
- `o_tdata` out 32: framed sample.
- `o_tlast` out 1: last sample of each frame.
- `o_tvalid` out 1: output valid.
- `o_tready` in 1: output ready.
- `o_frame_idx` out 16: index of the current frame within the burst (0-based), valid with `o_tvalid`.
- `busy` out 1: high while not IDLE.

## Operation
- Registers are 16-bit unsigned:
  - `SR_BASE+0` frame_len
  - `SR_BASE+1` gap_len
  - `SR_BASE+2` offset
  - `SR_BASE+3` num_frames
  - `SR_BASE+4` reserved (write accepted, no effect).
- Writes take effect on the next cycle.
- All four values are latched into shadow registers on the accepted trigger beat. Writes made during a burst do not affect that burst.
- frame_len value 0 is treated as 1.
- States:
  - IDLE: `i_tready`=1, `o_tvalid`=0. An accepted beat with `i_trigger`=1 and num_frames≠0 is counted as sample 0 and goes to OFFSET. If offset=0, it goes directly to FRAME and that beat is frame sample 0.
  - OFFSET: drop beats. The beat with running index offset-1 is the last dropped; the next state is FRAME.
  - FRAME: pass-through. `o_tvalid`=`i_tvalid`, `i_tready`=`o_tready`, `o_tdata`=`i_tdata`. Count accepted beats. `o_tlast`=1 on beat frame_len-1. After the last beat:
    - if frame_idx = num_frames-1, go to IDLE;
    - else if gap_len=0, start the next FRAME;
    - else go to GAP.
  - GAP: drop gap_len beats (`i_tready`=1, `o_tvalid`=0), then FRAME with frame_idx+1.
- Counters advance only on `i_tvalid & i_tready`.
- `i_trigger` is ignored outside IDLE; there is no retrigger mid-burst.
- Trigger with num_frames=0: the beat is dropped and the block stays IDLE.

## Timing
- Datapath is combinational gating: 0-cycle latency from input beat to output beat in FRAME.
- Control (state, counters, frame_idx) is registered and updates on the clock edge after the accepted beat.
- `o_tlast`, `o_frame_idx` and `busy` are decoded from registered state and counters; they are stable while `o_tvalid` is held with `o_tready`=0.
- Backpressure:
  - in FRAME, `o_tready`=0 stalls the input with no data loss;
  - in IDLE/OFFSET/GAP the input is never stalled.
- Reset values: state IDLE, all counters 0, shadows and registers = DEFAULT_*, `o_tvalid`=0, `o_tlast`=0, `o_frame_idx`=0, `busy`=0, `i_tready`=1.
- Reset asserted mid-burst aborts immediately. A partial frame is left without tlast; downstream must also be reset.
- Counter terminal compares use shadows; no wrap beyond 16 bits (max 65535 per field).

## Test plan
- Settings frame_len=64, gap=16, offset=29, num_frames=12; ramp input with sample value = index; trigger on sample 100 -> 12 frames of 64; frame k starts at value 129+80k (129, 209, …, 1009); tlast on 192, 272, …; 768 output beats; busy drops after value 1072.
- offset=0, gap=0, frame_len=4, num_frames=3, trigger on value 10 -> contiguous output 10..21, tlast on 13, 17, 21; `o_frame_idx` 0,0,0,0,1,…,2.
- Random `o_tready` (50%) and random `i_tvalid` gaps with the first scenario's settings -> identical output sequence; no beat is duplicated or lost.
- Second trigger during a burst (at value 300) -> ignored, output unchanged. Trigger after return to IDLE -> new burst starts.
- Write frame_len=32 mid-burst -> current burst keeps 64; the next burst uses 32. Trigger with num_frames=0 -> no output, busy stays 0.
- Assert reset during frame 3 -> outputs go to reset values asynchronously. After deassert, registers read back as defaults: a trigger yields one 64-sample frame at offset 0.
